// File: rtl/interrupt_acknowledge_master.sv
// rtl/interrupt_acknowledge_master.sv - INTA# pulse-train initiator with byte capture and vector handshake
module interrupt_acknowledge_master #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2,
  parameter int HOLDOFF_CYCLES  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_request,
  input  logic        interrupt_enable,
  input  logic        mode_8086,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        busy,
  output logic        vector_valid,
  input  logic        vector_ready,
  output logic [7:0]  vector,
  output logic [15:0] call_address,
  output logic        opcode_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK_LOW = 2'd1,
    ACK_GAP = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] LOW_LAST = 4'(INTA_LOW_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(INTA_GAP_CYCLES - 1);
  localparam logic [3:0] HOLDOFF  = 4'(HOLDOFF_CYCLES);
  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  state_t      state_q, state_d;
  logic        intr_meta_q, intr_sync_q;
  logic        mode_q, mode_d;
  logic [1:0]  pidx_q, pidx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  holdoff_q, holdoff_d;
  logic        inta_n_q, inta_n_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [7:0]  vector_q, vector_d;
  logic [15:0] call_q, call_d;
  logic        operr_q, operr_d;
  logic        last_pulse;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      intr_meta_q <= 1'b0;
      intr_sync_q <= 1'b0;
    end else begin
      intr_meta_q <= interrupt_request;
      intr_sync_q <= intr_meta_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      pidx_q    <= 2'd0;
      cnt_q     <= 4'd0;
      holdoff_q <= 4'd0;
      inta_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      vector_q  <= 8'h00;
      call_q    <= 16'h0000;
      operr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pidx_q    <= pidx_d;
      cnt_q     <= cnt_d;
      holdoff_q <= holdoff_d;
      inta_n_q  <= inta_n_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      vector_q  <= vector_d;
      call_q    <= call_d;
      operr_q   <= operr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pidx_d     = pidx_q;
    cnt_d      = cnt_q;
    holdoff_d  = holdoff_q;
    inta_n_d   = inta_n_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    vector_d   = vector_q;
    call_d     = call_q;
    operr_d    = operr_q;
    last_pulse = mode_q ? (pidx_q == 2'd1) : (pidx_q == 2'd2);

    case (state_q)
      IDLE: begin
        if (holdoff_q != 4'd0) begin
          holdoff_d = holdoff_q - 4'd1;
        end else if (intr_sync_q && interrupt_enable) begin
          state_d  = ACK_LOW;
          mode_d   = mode_8086;
          pidx_d   = 2'd0;
          cnt_d    = 4'd0;
          inta_n_d = 1'b0;
          busy_d   = 1'b1;
          vector_d = 8'h00;
          call_d   = 16'h0000;
          operr_d  = 1'b0;
        end
      end

      ACK_LOW: begin
        if (cnt_q == LOW_LAST) begin
          // Capture on the edge that ends the low phase, while the controller still drives the bus.
          if (mode_q) begin
            if (pidx_q == 2'd1) vector_d = data_bus_in;
          end else begin
            case (pidx_q)
              2'd0:    operr_d = (data_bus_in != CALL_OPCODE);
              2'd1: begin
                vector_d    = data_bus_in;
                call_d[7:0] = data_bus_in;
              end
              default: call_d[15:8] = data_bus_in;
            endcase
          end
          cnt_d    = 4'd0;
          inta_n_d = 1'b1;
          if (last_pulse) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            state_d = ACK_GAP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ACK_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d    = 4'd0;
          pidx_d   = pidx_q + 2'd1;
          inta_n_d = 1'b0;
          state_d  = ACK_LOW;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        if (valid_q && vector_ready) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          holdoff_d = HOLDOFF;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign interrupt_acknowledge_n = inta_n_q;
  assign busy                    = busy_q;
  assign vector_valid            = valid_q;
  assign vector                  = vector_q;
  assign call_address            = call_q;
  assign opcode_error            = operr_q;

endmodule
